mnist_nn_result_in: RTL and testbench

Avalon-MM slave input port: the read-side counterpart of the 16-bit output PIO through which the Nios II drives the floating-point datapath. Fabric logic (the MNIST NN result/status path) drives `in_port`. The block synchronizes it, exposes its level to the CPU, latches edges per bit into a sticky capture register, and raises a maskable level interrupt. It sits on the system interconnect next to the output PIO and uses the same 2-bit word address map.

---
 rtl/mnist_nn_result_in.sv | 88 ++++++++
 tb/tb_mnist_nn_result_in.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mnist_nn_result_in.sv
// Avalon-MM input PIO for the MNIST NN result/status path.
// It synchronizes in_port, captures per-bit edges in sticky flags and drives a maskable level irq.
module mnist_nn_result_in #(
  parameter int WIDTH     = 16,
  parameter int EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  logic [WIDTH-1:0] s1_q, s2_q, dly_q;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] edge_term;
  logic [WIDTH-1:0] wdata;
  logic             wr_mask;
  logic             wr_cap;
  logic             unused_wdata;

  // Bits of writedata above WIDTH are deliberately dropped.
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  assign wr_mask = chipselect && !write_n && (address == ADDR_IRQMASK);
  assign wr_cap  = chipselect && !write_n && (address == ADDR_EDGECAP);

  always_comb begin
    edge_term = s2_q & ~dly_q;
    if (EDGE_TYPE == 1) begin
      edge_term = ~s2_q & dly_q;
    end else if (EDGE_TYPE == 2) begin
      edge_term = s2_q ^ dly_q;
    end
  end

  // A capture arriving on the same edge as its W1C clear survives.
  always_comb begin
    irqmask_d = irqmask_q;
    edgecap_d = edgecap_q;
    if (wr_mask) begin
      irqmask_d = wdata;
    end
    if (wr_cap) begin
      edgecap_d = edgecap_q & ~wdata;
    end
    edgecap_d = edgecap_d | edge_term;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      dly_q     <= '0;
      irqmask_q <= '0;
      edgecap_q <= '0;
    end else begin
      s1_q      <= in_port;
      s2_q      <= s1_q;
      dly_q     <= s2_q;
      irqmask_q <= irqmask_d;
      edgecap_q <= edgecap_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = s2_q;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask_q;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap_q;
      default:      readdata = '0;
    endcase
  end

  assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_mnist_nn_result_in.sv
// Scoreboard bench for mnist_nn_result_in: a rising-edge instance and an any-edge instance share one bus.
`timescale 1ns/1ps
module tb_mnist_nn_result_in;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [15:0] in_port_r, in_port_a;
  logic [31:0] readdata_r, readdata_a;
  logic        irq_r, irq_a;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    string       tag;
    int          sel;
    int          addr;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  mnist_nn_result_in #(.WIDTH(16), .EDGE_TYPE(0)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port_r),
    .readdata(readdata_r), .irq(irq_r)
  );

  mnist_nn_result_in #(.WIDTH(16), .EDGE_TYPE(2)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port_a),
    .readdata(readdata_a), .irq(irq_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  // sel 0 = rising instance, 1 = any-edge instance; addr 4 = irq pin
  task automatic expect_rd(input string tag, input int sel, input int addr, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.sel = sel; e.addr = addr; e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] got;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.addr < 4) address = e.addr[1:0];
      #0.2;
      if (e.addr == 4) got = {31'd0, (e.sel == 0) ? irq_r : irq_a};
      else             got = (e.sel == 0) ? readdata_r : readdata_a;
      check_val(e.tag, got, e.val);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  initial begin
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    in_port_r = 16'h0000; in_port_a = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    expect_rd("rst_data",   0, 0, 32'h0);
    expect_rd("rst_rsvd",   0, 1, 32'h0);
    expect_rd("rst_mask",   0, 2, 32'h0);
    expect_rd("rst_cap",    0, 3, 32'h0);
    expect_rd("rst_irq",    0, 4, 32'h0);
    expect_rd("any_data_e", 1, 0, 32'h0);
    drain();

    tick(2);
    expect_rd("any_data_e1", 1, 0, 32'h0000FFFF);
    expect_rd("any_cap_e1",  1, 3, 32'h0);
    drain();
    tick();
    expect_rd("any_cap_rel", 1, 3, 32'h0000FFFF);
    expect_rd("any_irq_rel", 1, 4, 32'h0);
    drain();
    wr(2'd3, 32'h0000FFFF);
    expect_rd("any_cap_clr", 1, 3, 32'h0);
    drain();

    // rising edge with interrupt
    wr(2'd2, 32'hFFFF_0001);
    expect_rd("mask_trunc", 0, 2, 32'h1);
    drain();
    in_port_r = 16'h0001;
    tick(2);
    expect_rd("rise_data_e1", 0, 0, 32'h1);
    expect_rd("rise_cap_e1",  0, 3, 32'h0);
    expect_rd("rise_irq_e1",  0, 4, 32'h0);
    drain();
    tick();
    expect_rd("rise_cap_e2", 0, 3, 32'h1);
    expect_rd("rise_irq_e2", 0, 4, 32'h1);
    drain();

    wr(2'd0, 32'h0000_1234);
    expect_rd("data_ro", 0, 0, 32'h1);
    drain();
    wr(2'd3, 32'h1);
    expect_rd("w1c_cap", 0, 3, 32'h0);
    expect_rd("w1c_irq", 0, 4, 32'h0);
    drain();
    in_port_r = 16'h0000;
    tick(3);
    expect_rd("fall_data",  0, 0, 32'h0);
    expect_rd("fall_nocap", 0, 3, 32'h0);
    drain();

    // captured but masked, then unmasked
    wr(2'd2, 32'h0);
    in_port_r = 16'h0020;
    tick(3);
    expect_rd("b5_cap",    0, 3, 32'h20);
    expect_rd("b5_irq_m",  0, 4, 32'h0);
    drain();
    wr(2'd2, 32'h20);
    expect_rd("b5_irq_un", 0, 4, 32'h1);
    expect_rd("b5_cap_kp", 0, 3, 32'h20);
    drain();

    // set/clear collision on bit 2
    wr(2'd2, 32'h24);
    in_port_r = 16'h0024;
    tick(2);
    wr(2'd3, 32'h4);
    expect_rd("coll_cap", 0, 3, 32'h24);
    expect_rd("coll_irq", 0, 4, 32'h1);
    drain();
    wr(2'd3, 32'h20);
    expect_rd("clr_one_cap", 0, 3, 32'h4);
    expect_rd("clr_one_irq", 0, 4, 32'h1);
    drain();

    // any-edge mode on bit 15
    wr(2'd3, 32'hFFFF);
    wr(2'd2, 32'h8000);
    in_port_a = 16'h7FFF;
    tick(3);
    expect_rd("any_fall_cap", 1, 3, 32'h8000);
    expect_rd("any_fall_irq", 1, 4, 32'h1);
    expect_rd("rise_no_cap",  0, 3, 32'h0);
    drain();
    wr(2'd3, 32'h8000);
    expect_rd("any_clr_irq", 1, 4, 32'h0);
    drain();
    in_port_a = 16'hFFFF;
    tick(3);
    expect_rd("any_rise_cap", 1, 3, 32'h8000);
    expect_rd("any_rise_irq", 1, 4, 32'h1);
    drain();

    // asynchronous reset mid-operation
    in_port_r = 16'h0000;
    tick(3);
    wr(2'd3, 32'hFFFF);
    wr(2'd2, 32'h00FF);
    in_port_r = 16'h00FF;
    tick(3);
    expect_rd("pre_rst_cap", 0, 3, 32'hFF);
    expect_rd("pre_rst_irq", 0, 4, 32'h1);
    drain();
    #1 reset_n = 1'b0;
    expect_rd("arst_irq",  0, 4, 32'h0);
    expect_rd("arst_cap",  0, 3, 32'h0);
    expect_rd("arst_mask", 0, 2, 32'h0);
    expect_rd("arst_data", 0, 0, 32'h0);
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
